pn_code_gen: RTL

Parametrised dual-channel pseudo-noise chip generator for the spreading and scrambling path of the transmitter.
- Two Fibonacci LFSRs (A, B) with independent taps and seeds.
- Mode select chooses what each channel emits: single sequence, two independent sequences, or a Gold code.
- Each channel packs its last OUT_W chips into a parallel output word.
- Successor to the fixed 64-bit two-output code block: adds width, polynomial and seed parameters, modes, synchronous reload, period marker and chip counter.

---
 rtl/pn_code_gen_pkg.sv | 19 +
 rtl/pn_code_gen_if.sv | 25 ++
 rtl/pn_code_gen_lfsr_core.sv | 29 ++
 rtl/pn_code_gen.sv | 104 ++++++++++
 4 files changed

// File: rtl/pn_code_gen_pkg.sv
// Shared definitions for the dual-channel PN chip generator.
package pn_code_gen_pkg;

  // Channel-1 source selection; the unused encoding falls back to MODE_INV.
  typedef enum logic [1:0] {
    MODE_INV   = 2'b00,
    MODE_INDEP = 2'b01,
    MODE_GOLD  = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_e;

  // Maximal-length period 2^n-1; the chip counter wraps one below this.
  function automatic logic [31:0] seq_period(input int unsigned n);
    logic [32:0] p;
    p = (33'd1 << n) - 33'd1;
    return p[31:0];
  endfunction

endpackage

// File: rtl/pn_code_gen_if.sv
// Control and chip-output bundle between the generator and its user.
interface pn_code_gen_if #(
  parameter int LFSR_LEN = 5,
  parameter int OUT_W    = 64
);
  logic                en;
  logic                load;
  logic [1:0]          slt;
  logic                chip0;
  logic                chip1;
  logic [OUT_W-1:0]    output0;
  logic [OUT_W-1:0]    output1;
  logic                wrap;
  logic [LFSR_LEN-1:0] chipcnt;

  modport master (
    output en, load, slt,
    input  chip0, chip1, output0, output1, wrap, chipcnt
  );

  modport slave (
    input  en, load, slt,
    output chip0, chip1, output0, output1, wrap, chipcnt
  );
endinterface

// File: rtl/pn_code_gen_lfsr_core.sv
// Fibonacci LFSR: shifts left, feedback into bit 0, chip taken from the MSB.
module lfsr_core #(
  parameter int           N    = 5,
  parameter logic [N-1:0] TAPS = 5'b10010,
  parameter logic [N-1:0] SEED = 5'b00001
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         load,
  output logic         chip,
  output logic [N-1:0] state
);

  logic fb;

  assign fb   = ^(state & TAPS);
  assign chip = state[N-1];

  // State update: lock-up recovery first, then reload, then a normal step.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registers are assigned with <= so every flop samples pre-edge values.
    if (!rst_n)          state <= SEED;
    else if (~|state)    state <= SEED;
    else if (load)       state <= SEED;
    else if (en)         state <= {state[N-2:0], fb};
  end

endmodule

// File: rtl/pn_code_gen.sv
// Dual-channel PN chip generator: two LFSRs, mode mux, chip history,
// period counter and wrap marker.
module pn_code_gen
  import pn_code_gen_pkg::*;
#(
  parameter int                  LFSR_LEN = 5,
  parameter logic [LFSR_LEN-1:0] TAPS_A   = 5'b10010,
  parameter logic [LFSR_LEN-1:0] TAPS_B   = 5'b11110,
  parameter logic [LFSR_LEN-1:0] SEED_A   = 5'b00001,
  parameter logic [LFSR_LEN-1:0] SEED_B   = 5'b11111,
  parameter int                  OUT_W    = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  pn_code_gen_if.slave  bus
);

  localparam logic [LFSR_LEN-1:0] LAST_CNT =
    LFSR_LEN'(seq_period(LFSR_LEN) - 32'd1);

  logic                chip_a, chip_b;
  logic [LFSR_LEN-1:0] state_a, state_b;
  logic                ch0, ch1;

  logic                chip0_q, chip1_q, wrap_q;
  logic [OUT_W-1:0]    out0_q, out1_q;
  logic [LFSR_LEN-1:0] chipcnt_q;

  lfsr_core #(.N(LFSR_LEN), .TAPS(TAPS_A), .SEED(SEED_A)) u_lfsr_a (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bus.en),
    .load  (bus.load),
    .chip  (chip_a),
    .state (state_a)
  );

  lfsr_core #(.N(LFSR_LEN), .TAPS(TAPS_B), .SEED(SEED_B)) u_lfsr_b (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bus.en),
    .load  (bus.load),
    .chip  (chip_b),
    .state (state_b)
  );

  // Mode mux: channel 0 is always A; channel 1 depends on the selected mode.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    ch0 = chip_a;
    ch1 = ~chip_a;
    case (mode_e'(bus.slt))
      MODE_INDEP: ch1 = chip_b;
      MODE_GOLD:  ch1 = chip_a ^ chip_b;
      default:    ch1 = ~chip_a;
    endcase
  end

  // Chip registers, history shifters, period counter and wrap pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the history words are ordinary flops and clear on reset; a RAM would not.
      chip0_q   <= 1'b0;
      chip1_q   <= 1'b0;
      out0_q    <= '0;
      out1_q    <= '0;
      chipcnt_q <= '0;
      wrap_q    <= 1'b0;
    end else if (bus.load) begin
      chipcnt_q <= '0;
      wrap_q    <= 1'b0;
    end else if (bus.en) begin
      chip0_q <= ch0;
      chip1_q <= ch1;
      out0_q  <= {out0_q[OUT_W-2:0], ch0};
      out1_q  <= {out1_q[OUT_W-2:0], ch1};
      if (chipcnt_q == LAST_CNT) begin
        chipcnt_q <= '0;
        wrap_q    <= 1'b1;
      end else begin
        chipcnt_q <= chipcnt_q + LFSR_LEN'(1);
        wrap_q    <= 1'b0;
      end
    end else begin
      wrap_q <= 1'b0;
    end
  end

  // Invariants: LFSRs never sit at zero, and A is at its seed when Wrap fires.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (|state_a && |state_b);
      if (wrap_q) assert (state_a == SEED_A);
    end
  end

  assign bus.chip0   = chip0_q;
  assign bus.chip1   = chip1_q;
  assign bus.output0 = out0_q;
  assign bus.output1 = out1_q;
  assign bus.wrap    = wrap_q;
  assign bus.chipcnt = chipcnt_q;

endmodule
